// File: rtl/sap_pkg.sv
// Shared constants, control-word bit positions and loader state encoding
// for the SAP memory stage.
package sap_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;  // always 2**ADDR_W

  // Bit positions of the memory-stage strobes within the control word
  localparam int SIG_MAR_ADDR_LOAD_N = 11;
  localparam int SIG_MAR_MEM_LOAD_N  = 10;
  localparam int SIG_RAM_EN_N        = 9;
  localparam int SIG_RAM_LOAD_N      = 8;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_LOAD = 2'd1,
    L_DONE = 2'd2
  } ldr_state_t;

endpackage

// File: rtl/sap_ram16x8.sv
// DEPTH x DATA_W register-array RAM: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module sap_ram16x8
  import sap_pkg::*;
#(
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int DATA_W = sap_pkg::DATA_W,
  parameter int DEPTH  = sap_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store wdata at waddr on the clock edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_mem_unit.sv
// SAP memory stage: MAR, MDR and 16x8 RAM on the shared bus, plus a
// byte-stream program loader that owns the RAM while the CPU is held.
//
// state  | meaning
// -------+-------------------------------------------------------------
// L_IDLE | CPU mode: MAR/MDR/RAM strobes honoured, RAM readable on bus
// L_LOAD | loader accepts bytes into mem[ptr], CPU strobes ignored
// L_DONE | all words loaded, further bytes ignored until prog_mode drops
module sap_mem_unit
  import sap_pkg::*;
#(
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int DATA_W = sap_pkg::DATA_W,
  parameter int DEPTH  = sap_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_addr_load_n,
  input  logic              mar_mem_load_n,
  input  logic              ram_en_n,
  input  logic              ram_load_n,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [ADDR_W-1:0] mar_q,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done
);

  ldr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              ldr_we;
  logic              cpu_mode;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign cpu_mode = (state == L_IDLE);

  // Loader state and write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= L_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Loader next-state, pointer advance and handshake outputs
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    ldr_we     = 1'b0;
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    case (state)
      L_IDLE: begin
        if (prog_mode) begin
          state_nxt = L_LOAD;
          ptr_nxt   = '0;
        end
      end
      L_LOAD: begin
        prog_ready = 1'b1;
        if (prog_valid) begin
          ldr_we  = 1'b1;
          ptr_nxt = ptr + 1'b1;
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state_nxt = L_DONE;
          end
        end
        // Dropping prog_mode wins over completion; the byte still lands.
        if (!prog_mode) begin
          state_nxt = L_IDLE;
        end
      end
      L_DONE: begin
        prog_done = 1'b1;
        if (!prog_mode) begin
          state_nxt = L_IDLE;
        end
      end
      default: begin
        state_nxt = L_IDLE;
      end
    endcase
  end

  // MAR and MDR load only in CPU mode; the loader never touches them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar <= '0;
      mdr <= '0;
    end else if (cpu_mode) begin
      if (!mar_addr_load_n) begin
        mar <= bus_in[ADDR_W-1:0];
      end
      if (!mar_mem_load_n) begin
        mdr <= bus_in;
      end
    end
  end

  // CPU writes use the pre-edge MAR/MDR since both are registers
  assign ram_we    = cpu_mode ? !ram_load_n : ldr_we;
  assign ram_waddr = cpu_mode ? mar : ptr;
  assign ram_wdata = cpu_mode ? mdr : prog_data;

  sap_ram16x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar),
    .rdata (ram_rdata)
  );

  assign bus_oe  = cpu_mode && !ram_en_n;
  assign bus_out = bus_oe ? ram_rdata : '0;
  assign mar_q   = mar;

endmodule

// File: tb/tb_sap_mem_unit.sv
// Directed plus randomized bench for sap_mem_unit against a behavioural
// model of the memory stage (array RAM, MAR/MDR values, loader byte count).
module tb_sap_mem_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_in;
  logic       mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [3:0] mar_q;
  logic       prog_mode, prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready, prog_done;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model
  logic [7:0] m_mem [16];
  logic [3:0] m_mar;
  logic [7:0] m_mdr;
  bit         m_owned;   // loader owns the RAM
  int         m_count;   // bytes written since loader took ownership

  always #5 clk = ~clk;

  sap_mem_unit dut (
    .clk             (clk),
    .rst             (rst),
    .bus_in          (bus_in),
    .mar_addr_load_n (mar_addr_load_n),
    .mar_mem_load_n  (mar_mem_load_n),
    .ram_en_n        (ram_en_n),
    .ram_load_n      (ram_load_n),
    .bus_out         (bus_out),
    .bus_oe          (bus_oe),
    .mar_q           (mar_q),
    .prog_mode       (prog_mode),
    .prog_valid      (prog_valid),
    .prog_data       (prog_data),
    .prog_ready      (prog_ready),
    .prog_done       (prog_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic       e_oe;
    logic [7:0] e_out;
    e_oe  = !m_owned && !ram_en_n;
    e_out = e_oe ? m_mem[m_mar] : 8'h00;
    chk("mar_q", 32'(mar_q), 32'(m_mar));
    chk("bus_oe", 32'(bus_oe), 32'(e_oe));
    if (!$isunknown(e_out)) chk("bus_out", 32'(bus_out), 32'(e_out));
    chk("prog_ready", 32'(prog_ready), 32'(m_owned && m_count < 16));
    chk("prog_done", 32'(prog_done), 32'(m_owned && m_count == 16));
  endtask

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_edge();
    logic [3:0] mar_old;
    logic [7:0] mdr_old;
    if (!m_owned) begin
      mar_old = m_mar;
      mdr_old = m_mdr;
      if (!ram_load_n)      m_mem[mar_old] = mdr_old;
      if (!mar_addr_load_n) m_mar = bus_in[3:0];
      if (!mar_mem_load_n)  m_mdr = bus_in;
      if (prog_mode) begin
        m_owned = 1'b1;
        m_count = 0;
      end
    end else begin
      if (m_count < 16 && prog_valid) begin
        m_mem[m_count] = prog_data;
        m_count++;
      end
      if (!prog_mode) m_owned = 1'b0;
    end
  endtask

  // Settle, check outputs, then advance model and DUT through one edge
  task automatic tick();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes_idle();
    mar_addr_load_n = 1'b1;
    mar_mem_load_n  = 1'b1;
    ram_en_n        = 1'b1;
    ram_load_n      = 1'b1;
    prog_valid      = 1'b0;
  endtask

  task automatic set_mar(input logic [7:0] v);
    bus_in = v;
    mar_addr_load_n = 1'b0;
    tick();
    mar_addr_load_n = 1'b1;
  endtask

  task automatic read_at(input logic [3:0] a, input string tag, input logic [7:0] exp);
    set_mar({4'h0, a});
    ram_en_n = 1'b0;
    #1;
    chk(tag, 32'(bus_out), 32'(exp));
    check_all();
    ram_en_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 'x;
    m_mar = '0; m_mdr = '0; m_owned = 1'b0; m_count = 0;
    rst = 1'b1;
    bus_in = 8'h00;
    prog_mode = 1'b0;
    prog_data = 8'h00;
    strobes_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mar", 32'(mar_q), 32'h0);
    chk("rst_oe", 32'(bus_oe), 32'h0);
    chk("rst_out", 32'(bus_out), 32'h0);
    chk("rst_ready", 32'(prog_ready), 32'h0);
    chk("rst_done", 32'(prog_done), 32'h0);

    // Mid-cycle reset while the loader owns the RAM
    set_mar(8'h2B);
    chk("mar_upper_ignored", 32'(mar_q), 32'hB);
    prog_mode = 1'b1;
    tick();
    chk("enter_load_ready", 32'(prog_ready), 32'h1);
    rst = 1'b1;
    #2;
    chk("midrst_mar", 32'(mar_q), 32'h0);
    chk("midrst_ready", 32'(prog_ready), 32'h0);
    chk("midrst_done", 32'(prog_done), 32'h0);
    chk("midrst_oe", 32'(bus_oe), 32'h0);
    rst = 1'b0;
    prog_mode = 1'b0;
    m_mar = '0; m_mdr = '0; m_owned = 1'b0; m_count = 0;
    tick();

    // Full program load 0x10..0x1F, valid every cycle
    prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'h10 + 8'(i);
      #1;
      chk("load_ready", 32'(prog_ready), 32'h1);
      tick();
    end
    chk("load_done", 32'(prog_done), 32'h1);
    chk("load_ready_off", 32'(prog_ready), 32'h0);
    prog_data = 8'hEE;
    tick();
    prog_valid = 1'b0;
    prog_mode = 1'b0;
    tick();
    read_at(4'h5, "load_read5", 8'h15);
    read_at(4'h0, "load_read0", 8'h10);

    // CPU write 0x99 to address 0xA
    set_mar(8'h2A);
    chk("cpu_mar", 32'(mar_q), 32'hA);
    bus_in = 8'h99;
    mar_mem_load_n = 1'b0;
    tick();
    mar_mem_load_n = 1'b1;
    ram_load_n = 1'b0;
    ram_en_n = 1'b0;
    #1;
    chk("rdw_old_data", 32'(bus_out), 32'h1A);
    tick();
    ram_load_n = 1'b1;
    #1;
    chk("cpu_read", 32'(bus_out), 32'h99);
    chk("cpu_oe", 32'(bus_oe), 32'h1);
    ram_en_n = 1'b1;

    // Simultaneous MAR, MDR and RAM load on one edge
    set_mar(8'h03);
    bus_in = 8'h44;
    mar_mem_load_n = 1'b0;
    tick();
    bus_in = 8'h07;
    mar_addr_load_n = 1'b0;
    ram_load_n = 1'b0;
    tick();
    strobes_idle();
    chk("simul_mar", 32'(mar_q), 32'h7);
    ram_en_n = 1'b0;
    #1;
    chk("simul_mem7", 32'(bus_out), 32'h17);
    ram_en_n = 1'b1;
    read_at(4'h3, "simul_mem3", 8'h44);
    ram_load_n = 1'b0;          // writes MDR (0x07) into mem[3]
    tick();
    ram_load_n = 1'b1;
    ram_en_n = 1'b0;
    #1;
    chk("simul_mdr", 32'(bus_out), 32'h07);
    ram_en_n = 1'b1;

    // Back-pressure then abort after 8 bytes
    prog_mode = 1'b1;
    tick();
    for (int c = 0; c < 11; c++) begin
      prog_valid = !(c >= 3 && c < 6);
      prog_data  = 8'hA0 + 8'(m_count);
      tick();
    end
    prog_valid = 1'b0;
    prog_mode = 1'b0;
    tick();
    chk("abort_done", 32'(prog_done), 32'h0);
    read_at(4'h7, "abort_mem7", 8'hA7);
    read_at(4'h8, "abort_mem8", 8'h18);
    for (int a = 0; a < 16; a++) read_at(4'(a), "abort_mem", m_mem[a]);

    // Isolation: CPU strobes ignored while loading
    prog_mode = 1'b1;
    tick();
    bus_in = 8'h0C;
    mar_addr_load_n = 1'b0;
    mar_mem_load_n = 1'b0;
    ram_en_n = 1'b0;
    ram_load_n = 1'b0;
    #1;
    chk("iso_oe", 32'(bus_oe), 32'h0);
    chk("iso_out", 32'(bus_out), 32'h0);
    tick();
    tick();
    strobes_idle();
    prog_mode = 1'b0;
    tick();
    chk("iso_mar", 32'(mar_q), 32'hF);
    for (int a = 0; a < 16; a++) read_at(4'(a), "iso_mem", m_mem[a]);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus_in          = 8'($urandom);
      mar_addr_load_n = ($urandom_range(0, 2) != 0);
      mar_mem_load_n  = ($urandom_range(0, 2) != 0);
      ram_en_n        = ($urandom_range(0, 1) != 0);
      ram_load_n      = ($urandom_range(0, 2) != 0);
      prog_valid      = ($urandom_range(0, 1) != 0);
      prog_data       = 8'($urandom);
      if ($urandom_range(0, 11) == 0) prog_mode = !prog_mode;
      tick();
    end
    strobes_idle();
    prog_mode = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) read_at(4'(a), "rand_mem", m_mem[a]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
